// File: rtl/timer_sched.sv
// SFR front end and slot scheduler for the shared timer datapath.
// Each machine-cycle tick serves timer 0, then timer 1, with write-back.
module timer_sched #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ADDR_TCON   = 8'h88,
    parameter logic [7:0] ADDR_TMOD   = 8'h89,
    parameter logic [7:0] ADDR_TL0    = 8'h8A,
    parameter logic [7:0] ADDR_TL1    = 8'h8B,
    parameter logic [7:0] ADDR_TH0    = 8'h8C,
    parameter logic [7:0] ADDR_TH1    = 8'h8D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mc_tick,
    input  logic [7:0] sfr_addr,
    input  logic       sfr_we,
    input  logic [7:0] sfr_wdata,
    output logic [7:0] sfr_rdata,
    input  logic       t0_pin,
    input  logic       t1_pin,
    input  logic       int0_n,
    input  logic       int1_n,
    input  logic       tf0_clr,
    input  logic       tf1_clr,
    output logic       tf0,
    output logic       tf1,
    output logic       dp_cnt_sig,
    output logic       dp_t_s,
    output logic [3:0] dp_tmod,
    output logic [7:0] dp_th,
    output logic [7:0] dp_tl,
    input  logic [7:0] dp_th_nxt,
    input  logic [7:0] dp_tl_nxt,
    input  logic       dp_t_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] S_T0 = 2'd1;
    localparam logic [1:0] S_T1 = 2'd2;

    logic [1:0] state;
    logic       pending;
    logic [7:0] tmod, th0, tl0, th1, tl1;
    logic       tr0, tr1;
    logic       ev0, ev1, pl0, pl1;
    logic [SYNC_STAGES-1:0] sy_t0, sy_t1, sy_i0, sy_i1;
    logic t0_s, t1_s, i0_s, i1_s;

    assign t0_s = sy_t0[SYNC_STAGES-1];
    assign t1_s = sy_t1[SYNC_STAGES-1];
    assign i0_s = sy_i0[SYNC_STAGES-1];
    assign i1_s = sy_i1[SYNC_STAGES-1];

    logic start, t1_m3;
    logic wr_tcon, wr_tmod, wr_th0, wr_tl0, wr_th1, wr_tl1;
    logic wb0, wb1, set0, set1;

    assign start   = (state == IDLE) & (mc_tick | pending);
    assign t1_m3   = (tmod[5:4] == 2'b11);
    assign wr_tcon = sfr_we & (sfr_addr == ADDR_TCON);
    assign wr_tmod = sfr_we & (sfr_addr == ADDR_TMOD);
    assign wr_th0  = sfr_we & (sfr_addr == ADDR_TH0);
    assign wr_tl0  = sfr_we & (sfr_addr == ADDR_TL0);
    assign wr_th1  = sfr_we & (sfr_addr == ADDR_TH1);
    assign wr_tl1  = sfr_we & (sfr_addr == ADDR_TL1);
    // An SFR write to either byte of the slot's timer cancels the whole write-back
    assign wb0  = (state == S_T0) & ~(wr_th0 | wr_tl0);
    assign wb1  = (state == S_T1) & ~(wr_th1 | wr_tl1) & ~t1_m3;
    assign set0 = (state == S_T0) & dp_t_o;
    assign set1 = (state == S_T1) & dp_t_o & ~t1_m3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sy_t0 <= '0;
            sy_t1 <= '0;
            sy_i0 <= '0;
            sy_i1 <= '0;
        end else begin
            sy_t0 <= {sy_t0[SYNC_STAGES-2:0], t0_pin};
            sy_t1 <= {sy_t1[SYNC_STAGES-2:0], t1_pin};
            sy_i0 <= {sy_i0[SYNC_STAGES-2:0], int0_n};
            sy_i1 <= {sy_i1[SYNC_STAGES-2:0], int1_n};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= 1'b0;
            ev0     <= 1'b0;
            ev1     <= 1'b0;
            pl0     <= 1'b0;
            pl1     <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start) state <= S_T0;
                S_T0:    state <= S_T1;
                default: state <= IDLE;
            endcase
            if (state == IDLE) pending <= pending & mc_tick;
            else if (mc_tick) pending <= 1'b1;
            if (start) begin
                ev0 <= ~tmod[2] | (pl0 & ~t0_s);
                ev1 <= ~tmod[6] | (pl1 & ~t1_s);
                pl0 <= t0_s;
                pl1 <= t1_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmod <= '0;
            th0  <= '0;
            tl0  <= '0;
            th1  <= '0;
            tl1  <= '0;
            tr0  <= 1'b0;
            tr1  <= 1'b0;
            tf0  <= 1'b0;
            tf1  <= 1'b0;
        end else begin
            if (wr_tmod) tmod <= sfr_wdata;
            if (wr_th0) th0 <= sfr_wdata;
            else if (wb0 && tmod[1:0] != 2'b11) th0 <= dp_th_nxt;
            if (wr_tl0) tl0 <= sfr_wdata;
            else if (wb0) tl0 <= dp_tl_nxt;
            if (wr_th1) th1 <= sfr_wdata;
            else if (wb1) th1 <= dp_th_nxt;
            if (wr_tl1) tl1 <= sfr_wdata;
            else if (wb1) tl1 <= dp_tl_nxt;
            if (wr_tcon) begin
                tr0 <= sfr_wdata[4];
                tr1 <= sfr_wdata[6];
            end
            // Hardware set wins over both the ack and a clearing TCON write
            tf0 <= set0 | (wr_tcon ? sfr_wdata[5] : (tf0 & ~tf0_clr));
            tf1 <= set1 | (wr_tcon ? sfr_wdata[7] : (tf1 & ~tf1_clr));
        end
    end

    always_comb begin
        dp_cnt_sig = 1'b0;
        dp_t_s     = 1'b0;
        dp_tmod    = 4'd0;
        dp_th      = 8'd0;
        dp_tl      = 8'd0;
        case (state)
            S_T0: begin
                dp_cnt_sig = ev0;
                dp_t_s     = tr0 & (~tmod[3] | i0_s);
                dp_tmod    = tmod[3:0];
                dp_th      = th0;
                dp_tl      = tl0;
            end
            S_T1: begin
                dp_cnt_sig = ev1;
                dp_t_s     = tr1 & (~tmod[7] | i1_s) & ~t1_m3;
                dp_tmod    = tmod[7:4];
                dp_th      = th1;
                dp_tl      = tl1;
            end
            default: ;
        endcase
    end

    always_comb begin
        sfr_rdata = 8'd0;
        case (sfr_addr)
            ADDR_TCON: sfr_rdata = {tf1, tr1, tf0, tr0, 4'b0000};
            ADDR_TMOD: sfr_rdata = tmod;
            ADDR_TL0:  sfr_rdata = tl0;
            ADDR_TL1:  sfr_rdata = tl1;
            ADDR_TH0:  sfr_rdata = th0;
            ADDR_TH1:  sfr_rdata = th1;
            default:   sfr_rdata = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_sched.sv
// Directed + randomized bench for timer_sched with a stand-in timer
// datapath and an arithmetic reference model of both timers.
module tb_timer_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mc_tick = 1'b0;
    logic [7:0] sfr_addr = 8'h00;
    logic       sfr_we = 1'b0;
    logic [7:0] sfr_wdata = 8'h00;
    logic [7:0] sfr_rdata;
    logic       t0_pin = 1'b0;
    logic       t1_pin = 1'b0;
    logic       int0_n = 1'b1;
    logic       int1_n = 1'b1;
    logic       tf0_clr = 1'b0;
    logic       tf1_clr = 1'b0;
    logic       tf0, tf1;
    logic       dp_cnt_sig, dp_t_s;
    logic [3:0] dp_tmod;
    logic [7:0] dp_th, dp_tl;
    logic [7:0] dp_th_nxt, dp_tl_nxt;
    logic       dp_t_o;

    timer_sched dut (
        .clk(clk), .rst_n(rst_n), .mc_tick(mc_tick),
        .sfr_addr(sfr_addr), .sfr_we(sfr_we),
        .sfr_wdata(sfr_wdata), .sfr_rdata(sfr_rdata),
        .t0_pin(t0_pin), .t1_pin(t1_pin),
        .int0_n(int0_n), .int1_n(int1_n),
        .tf0_clr(tf0_clr), .tf1_clr(tf1_clr),
        .tf0(tf0), .tf1(tf1),
        .dp_cnt_sig(dp_cnt_sig), .dp_t_s(dp_t_s),
        .dp_tmod(dp_tmod), .dp_th(dp_th), .dp_tl(dp_tl),
        .dp_th_nxt(dp_th_nxt), .dp_tl_nxt(dp_tl_nxt),
        .dp_t_o(dp_t_o)
    );

    always #5 clk = ~clk;

    // Stand-in shared timer datapath
    always_comb begin
        dp_th_nxt = dp_th;
        dp_tl_nxt = dp_tl;
        dp_t_o    = 1'b0;
        if (dp_cnt_sig && dp_t_s) begin
            case (dp_tmod[1:0])
                2'd0: begin
                    dp_tl_nxt = dp_tl + 8'd1;
                    if (dp_tl[4:0] == 5'h1F)
                        {dp_t_o, dp_th_nxt} = {1'b0, dp_th} + 9'd1;
                end
                2'd1: {dp_t_o, dp_th_nxt, dp_tl_nxt} =
                      {1'b0, dp_th, dp_tl} + 17'd1;
                2'd2: begin
                    if (dp_tl == 8'hFF) begin
                        dp_tl_nxt = dp_th;
                        dp_t_o    = 1'b1;
                    end else begin
                        dp_tl_nxt = dp_tl + 8'd1;
                    end
                end
                default: {dp_t_o, dp_tl_nxt} = {1'b0, dp_tl} + 9'd1;
            endcase
        end
    end

    int vecs = 0;
    int miscompares = 0;

    int m_tl[2], m_th[2];
    bit m_tf[2], m_tr[2], m_prev[2];
    int m_tmod;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_tl[i] = 0; m_th[i] = 0;
            m_tf[i] = 0; m_tr[i] = 0; m_prev[i] = 0;
        end
        m_tmod = 0;
    endtask

    task automatic model_adv(input int x, input int mode);
        bit ovf;
        int v;
        ovf = 0;
        case (mode)
            0: begin
                m_tl[x] = (m_tl[x] + 1) % 256;
                if (m_tl[x] % 32 == 0) begin
                    m_th[x] = (m_th[x] + 1) % 256;
                    ovf = (m_th[x] == 0);
                end
            end
            1: begin
                v = (m_th[x] * 256 + m_tl[x] + 1) % 65536;
                ovf = (v == 0);
                m_th[x] = v / 256;
                m_tl[x] = v % 256;
            end
            2: begin
                if (m_tl[x] == 255) begin
                    m_tl[x] = m_th[x];
                    ovf = 1;
                end else begin
                    m_tl[x] = m_tl[x] + 1;
                end
            end
            default: begin
                m_tl[x] = (m_tl[x] + 1) % 256;
                ovf = (m_tl[x] == 0);
            end
        endcase
        if (ovf) m_tf[x] = 1;
    endtask

    task automatic model_tick();
        int nib;
        bit pin, intn, ev, run;
        for (int x = 0; x < 2; x++) begin
            nib  = (x == 0) ? (m_tmod % 16) : (m_tmod / 16);
            pin  = (x == 0) ? t0_pin : t1_pin;
            intn = (x == 0) ? int0_n : int1_n;
            ev   = ((nib & 4) != 0) ? (m_prev[x] & ~pin) : 1'b1;
            m_prev[x] = pin;
            run = m_tr[x] & (((nib & 8) == 0) | intn);
            if (!(x == 1 && (nib % 4) == 3) && run && ev)
                model_adv(x, nib % 4);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        sfr_addr  = a;
        sfr_wdata = d;
        sfr_we    = 1'b1;
        case (a)
            8'h88: begin
                m_tf[1] = d[7]; m_tr[1] = d[6];
                m_tf[0] = d[5]; m_tr[0] = d[4];
            end
            8'h89: m_tmod = d;
            8'h8A: m_tl[0] = d;
            8'h8B: m_tl[1] = d;
            8'h8C: m_th[0] = d;
            8'h8D: m_th[1] = d;
            default: ;
        endcase
        step();
        sfr_we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        sfr_addr = a;
        #1;
        d = sfr_rdata;
    endtask

    task automatic tick();
        mc_tick = 1'b1;
        step();
        mc_tick = 1'b0;
        step();
        step();
        step();
        model_tick();
    endtask

    task automatic check_all(input string tag);
        logic [7:0] d;
        rd(8'h88, d);
        check({tag, ".tcon"}, d,
              {m_tf[1], m_tr[1], m_tf[0], m_tr[0], 4'b0000});
        rd(8'h89, d); check({tag, ".tmod"}, d, 8'(m_tmod));
        rd(8'h8A, d); check({tag, ".tl0"}, d, 8'(m_tl[0]));
        rd(8'h8B, d); check({tag, ".tl1"}, d, 8'(m_tl[1]));
        rd(8'h8C, d); check({tag, ".th0"}, d, 8'(m_th[0]));
        rd(8'h8D, d); check({tag, ".th1"}, d, 8'(m_th[1]));
        check({tag, ".tf"}, {6'd0, tf1, tf0}, {6'd0, m_tf[1], m_tf[0]});
    endtask

    task automatic check_dp_idle(input string tag);
        check(tag, {dp_cnt_sig, dp_t_s, dp_tmod, 2'b00}, 8'h00);
        check({tag, ".th"}, dp_th, 8'h00);
        check({tag, ".tl"}, dp_tl, 8'h00);
    endtask

    initial begin
        logic [7:0] d, held;
        int r;

        // 1: reset state, then free-running mode 0 from TL0=200
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_all("reset");
        check_dp_idle("reset.dp");
        rd(8'h80, d); check("unmapped", d, 8'h00);
        wr(8'h89, 8'h00);
        wr(8'h8A, 8'd200);
        wr(8'h8C, 8'h00);
        wr(8'h88, 8'h10);
        mc_tick = 1'b1;
        step();
        mc_tick = 1'b0;
        rd(8'h8A, d); check("t1.lat_n1", d, 8'd200);
        step();
        rd(8'h8A, d); check("t1.lat_n2", d, 8'd201);
        step(); step();
        model_tick();
        for (int i = 1; i < 56; i++) tick();
        rd(8'h8A, d); check("t1.tl0_wrap", d, 8'h00);
        check_all("t1");

        // 2: mode 2 auto-reload and overflow vs. ack collision
        wr(8'h89, 8'h02);
        wr(8'h8C, 8'hF0);
        wr(8'h8A, 8'hFE);
        wr(8'h88, 8'h10);
        tick();
        tick();
        rd(8'h8A, d); check("t2.reload", d, 8'hF0);
        check("t2.tf0", {7'd0, tf0}, 8'h01);
        tf0_clr = 1'b1;
        step();
        tf0_clr = 1'b0;
        m_tf[0] = 0;
        check("t2.clr", {7'd0, tf0}, 8'h00);
        for (int i = 0; i < 15; i++) tick();
        mc_tick = 1'b1;
        step();
        mc_tick = 1'b0;
        tf0_clr = 1'b1;
        step();
        tf0_clr = 1'b0;
        step(); step();
        model_tick();
        check("t2.set_beats_clr", {7'd0, tf0}, 8'h01);
        check_all("t2");

        // 3: counter mode on falling T0 edges, then gated off
        wr(8'h89, 8'h05);
        wr(8'h8A, 8'h00);
        wr(8'h8C, 8'h00);
        wr(8'h88, 8'h10);
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) begin
                t0_pin = ~t0_pin;
                step(); step(); step();
            end
            tick();
            check_all("t3.cnt");
        end
        wr(8'h89, 8'h0D);
        int0_n = 1'b0;
        rd(8'h8A, held);
        for (int i = 0; i < 6; i++) begin
            t0_pin = ~t0_pin;
            step(); step(); step();
            tick();
        end
        rd(8'h8A, d); check("t3.gated", d, held);
        check_all("t3.gate");
        int0_n = 1'b1;

        // 4: tick burst, pending absorbs one, T0 before T1
        wr(8'h89, 8'h11);
        wr(8'h8A, 8'h10);
        wr(8'h8B, 8'h80);
        wr(8'h8C, 8'h00);
        wr(8'h8D, 8'h00);
        wr(8'h88, 8'h50);
        mc_tick = 1'b1;
        step();
        check("t4.s0_tl", dp_tl, 8'h10);
        check("t4.s0_tmod", {4'd0, dp_tmod}, 8'h01);
        step();
        check("t4.s1_tl", dp_tl, 8'h80);
        step();
        mc_tick = 1'b0;
        check_dp_idle("t4.idle");
        step();
        check("t4.p0_tl", dp_tl, 8'h11);
        step();
        check("t4.p1_tl", dp_tl, 8'h81);
        step(); step(); step();
        model_tick();
        model_tick();
        check_all("t4");

        // 5: SFR write during T1 slot wins, then T1 mode 3 freezes
        wr(8'h88, 8'h40);
        wr(8'h89, 8'h10);
        wr(8'h8B, 8'h20);
        mc_tick = 1'b1;
        step();
        mc_tick = 1'b0;
        step();
        model_tick();
        wr(8'h8B, 8'h55);
        step();
        rd(8'h8B, d); check("t5.sfr_wins", d, 8'h55);
        check_all("t5.wr");
        wr(8'h89, 8'h30);
        wr(8'h8B, 8'hFF);
        wr(8'h8D, 8'hFF);
        for (int i = 0; i < 3; i++) tick();
        rd(8'h8B, d); check("t5.frozen", d, 8'hFF);
        check("t5.tf1", {7'd0, tf1}, 8'h00);
        check_all("t5.m3");

        // randomized traffic against the reference model
        for (int it = 0; it < 120; it++) begin
            r = $urandom_range(0, 6);
            case (r)
                0: wr(8'h89, 8'($urandom));
                1: wr(8'($urandom_range(8'h8A, 8'h8D)), 8'($urandom));
                2: wr(8'h88, 8'($urandom));
                3: begin
                    t0_pin = 1'($urandom);
                    t1_pin = 1'($urandom);
                    int0_n = 1'($urandom);
                    int1_n = 1'($urandom);
                    step(); step(); step();
                end
                default: begin
                    tick();
                    check_all("rand");
                end
            endcase
        end

        // 6: reset in the middle of the T0 slot
        wr(8'h89, 8'h01);
        wr(8'h88, 8'h10);
        mc_tick = 1'b1;
        step();
        mc_tick = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_dp_idle("t6.in_rst");
        step();
        rst_n = 1'b1;
        step();
        check_all("t6");
        check_dp_idle("t6.dp");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miscompares);
        $finish;
    end

endmodule
